// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the bubble instruction and the sequential PC step.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned NOP_INSTR = 0;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC priority mux: misaligned redirect, redirect, stall, increment.
// Zero latency to imem address; holds whenever the fetch FSM is not running.
module fetch_pc_reg #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc4_o,
    output logic              misaligned_o
);
    import instr_fetch_unit_pkg::*;

    logic [ADDR_W-1:0] pc_q;

    assign pc_o         = pc_q;
    assign pc4_o        = pc_q + ADDR_W'(PC_INC);
    assign misaligned_o = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (run_i && !misaligned_o) begin
            // An aligned redirect overrides a concurrent stall.
            if (redirect_valid_i)
                pc_q <= redirect_pc_i;
            else if (!stall_i)
                pc_q <= pc4_o;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register, WAIT/RUN/HALT control and fetch counter.
// One-cycle fetch latency; stall holds PC and IF/ID, flush/redirect insert a bubble.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_valid_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               ifid_valid_o,
    output logic [ADDR_W-1:0]  ifid_pc_o,
    output logic [ADDR_W-1:0]  ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               halted_o,
    output logic [CNT_W-1:0]   fetch_count_o
);
    import instr_fetch_unit_pkg::*;

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("instr_fetch_unit: RESET_PC must be word-aligned");
    end

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic              misaligned;
    logic              run;
    logic              ifid_load;
    logic              ifid_clr;

    assign run         = (state_q == ST_RUN);
    assign imem_addr_o = pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .run_i            (run),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc),
        .pc4_o            (pc4),
        .misaligned_o     (misaligned)
    );

    // Flush wins over stall for IF/ID; any redirect bubbles IF/ID regardless of stall.
    always_comb begin
        ifid_load = 1'b0;
        ifid_clr  = 1'b0;
        if (run) begin
            if (redirect_valid_i || flush_i)
                ifid_clr = 1'b1;
            else if (!stall_i)
                ifid_load = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_WAIT;
            halted_o      <= 1'b0;
            ifid_valid_o  <= 1'b0;
            ifid_pc_o     <= '0;
            ifid_pc4_o    <= '0;
            ifid_instr_o  <= INSTR_W'(NOP_INSTR);
            fetch_count_o <= '0;
        end else begin
            case (state_q)
                ST_WAIT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (misaligned) begin
                        state_q  <= ST_HALT;
                        halted_o <= 1'b1;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_WAIT;
            endcase

            if (ifid_clr) begin
                ifid_valid_o <= 1'b0;
                ifid_pc_o    <= '0;
                ifid_pc4_o   <= '0;
                ifid_instr_o <= INSTR_W'(NOP_INSTR);
            end else if (ifid_load) begin
                ifid_valid_o <= 1'b1;
                ifid_pc_o    <= pc;
                ifid_pc4_o   <= pc4;
                ifid_instr_o <= imem_data_i;
                if (fetch_count_o != {CNT_W{1'b1}})
                    fetch_count_o <= fetch_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences, random vs reference model.
module tb_instr_fetch_unit;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        halted_o;
    logic [CNT_W-1:0] fetch_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1111_0000 + a;
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_data_i      (imem_data_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_pc4_o       (ifid_pc4_o),
        .ifid_instr_o     (ifid_instr_o),
        .halted_o         (halted_o),
        .fetch_count_o    (fetch_count_o)
    );

    // Reference model: pipeline contents described directly from the fetch rules.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_halt, m_waiting;
    int          m_cnt;

    task automatic m_bubble();
        m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0;
    endtask

    task automatic model_step(input logic r, s, f, rv, input logic [31:0] rp);
        if (r) begin
            m_pc = 0; m_waiting = 1; m_halt = 0; m_cnt = 0;
            m_bubble();
        end else if (m_halt) begin
            // frozen until reset
        end else if (m_waiting) begin
            m_waiting = 0;
        end else if (rv && (rp % 4 != 0)) begin
            m_halt = 1;
            m_bubble();
        end else if (rv) begin
            m_pc = rp;
            m_bubble();
        end else if (s) begin
            if (f) m_bubble();
        end else begin
            if (f) begin
                m_bubble();
            end else begin
                m_valid = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mem_word(m_pc);
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " addr"},  64'(imem_addr_o),   64'(m_pc));
        chk({tag, " valid"}, 64'(ifid_valid_o),  64'(m_valid));
        chk({tag, " pc"},    64'(ifid_pc_o),     64'(m_ipc));
        chk({tag, " pc4"},   64'(ifid_pc4_o),    64'(m_ipc4));
        chk({tag, " instr"}, 64'(ifid_instr_o),  64'(m_instr));
        chk({tag, " halt"},  64'(halted_o),      64'(m_halt));
        chk({tag, " cnt"},   64'(fetch_count_o), 64'(m_cnt));
    endtask

    // Drive at negedge, clock once, observe at the following negedge.
    task automatic step(input logic r, s, f, rv, input logic [31:0] rp);
        rst_i = r; stall_i = s; flush_i = f; redirect_valid_i = rv; redirect_pc_i = rp;
        @(posedge clk_i);
        model_step(r, s, f, rv, rp);
        @(negedge clk_i);
        rst_i = 0; stall_i = 0; flush_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
    endtask

    typedef struct {
        logic        s, f, rv;
        logic [31:0] rp;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_halt;
        int          e_cnt;
    } vec_t;

    vec_t vt[16];

    initial begin
        //        s  f  rv  rp          addr   v  ifid_pc instr         halt cnt
        vt[0]  = '{0, 0, 0, 32'h0,  32'h00, 0, 32'h00, 32'h0,          0, 0};
        vt[1]  = '{0, 0, 0, 32'h0,  32'h04, 1, 32'h00, 32'h1111_0000,  0, 1};
        vt[2]  = '{0, 0, 0, 32'h0,  32'h08, 1, 32'h04, 32'h1111_0004,  0, 2};
        vt[3]  = '{1, 0, 0, 32'h0,  32'h08, 1, 32'h04, 32'h1111_0004,  0, 2};
        vt[4]  = '{1, 1, 0, 32'h0,  32'h08, 0, 32'h00, 32'h0,          0, 2};
        vt[5]  = '{1, 0, 0, 32'h0,  32'h08, 0, 32'h00, 32'h0,          0, 2};
        vt[6]  = '{0, 0, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h1111_0008,  0, 3};
        vt[7]  = '{0, 0, 0, 32'h0,  32'h10, 1, 32'h0C, 32'h1111_000C,  0, 4};
        vt[8]  = '{1, 0, 1, 32'h40, 32'h40, 0, 32'h00, 32'h0,          0, 4};
        vt[9]  = '{0, 0, 0, 32'h0,  32'h44, 1, 32'h40, 32'h1111_0040,  0, 5};
        vt[10] = '{0, 1, 0, 32'h0,  32'h48, 0, 32'h00, 32'h0,          0, 5};
        vt[11] = '{0, 0, 1, 32'h48, 32'h48, 0, 32'h00, 32'h0,          0, 5};
        vt[12] = '{0, 0, 0, 32'h0,  32'h4C, 1, 32'h48, 32'h1111_0048,  0, 6};
        vt[13] = '{0, 0, 1, 32'h42, 32'h4C, 0, 32'h00, 32'h0,          1, 6};
        vt[14] = '{0, 1, 1, 32'h80, 32'h4C, 0, 32'h00, 32'h0,          1, 6};
        vt[15] = '{1, 0, 0, 32'h0,  32'h4C, 0, 32'h00, 32'h0,          1, 6};

        // Reset state while rst_i is held.
        @(negedge clk_i);
        chk("rst addr",  64'(imem_addr_o),   64'h0);
        chk("rst valid", 64'(ifid_valid_o),  64'h0);
        chk("rst instr", 64'(ifid_instr_o),  64'h0);
        chk("rst halt",  64'(halted_o),      64'h0);
        chk("rst cnt",   64'(fetch_count_o), 64'h0);
        step(1, 0, 0, 0, 0);
        chk("wait addr",  64'(imem_addr_o),  64'h0);
        chk("wait valid", 64'(ifid_valid_o), 64'h0);

        for (int i = 0; i < 16; i++) begin
            step(0, vt[i].s, vt[i].f, vt[i].rv, vt[i].rp);
            chk($sformatf("vec%0d addr", i),  64'(imem_addr_o),   64'(vt[i].e_addr));
            chk($sformatf("vec%0d valid", i), 64'(ifid_valid_o),  64'(vt[i].e_valid));
            chk($sformatf("vec%0d pc", i),    64'(ifid_pc_o),     64'(vt[i].e_pc));
            chk($sformatf("vec%0d pc4", i),   64'(ifid_pc4_o),
                vt[i].e_valid ? 64'(vt[i].e_pc + 32'd4) : 64'h0);
            chk($sformatf("vec%0d instr", i), 64'(ifid_instr_o),  64'(vt[i].e_instr));
            chk($sformatf("vec%0d halt", i),  64'(halted_o),      64'(vt[i].e_halt));
            chk($sformatf("vec%0d cnt", i),   64'(fetch_count_o), 64'(vt[i].e_cnt));
        end

        // Asynchronous reset out of HALT, mid-cycle.
        #2 rst_i = 1;
        #1;
        chk("async halt", 64'(halted_o),      64'h0);
        chk("async addr", 64'(imem_addr_o),   64'h0);
        chk("async cnt",  64'(fetch_count_o), 64'h0);
        @(negedge clk_i);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("restart valid", 64'(ifid_valid_o), 64'h1);
        chk("restart pc",    64'(ifid_pc_o),    64'h0);

        // Address wrap-around.
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap addr",  64'(imem_addr_o), 64'h0);
        chk("wrap pc",    64'(ifid_pc_o),   64'hFFFF_FFFC);
        chk("wrap pc4",   64'(ifid_pc4_o),  64'h0);
        chk("wrap instr", 64'(ifid_instr_o), 64'(mem_word(32'hFFFF_FFFC)));

        // Counter saturation.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 7)  chk("sat cnt7",  64'(fetch_count_o), 64'd7);
            if (i == 10) chk("sat cnt10", 64'(fetch_count_o), 64'd7);
        end

        // Randomized traffic against the reference model.
        step(1, 0, 0, 0, 0);
        chk_model("rnd start");
        for (int i = 0; i < 800; i++) begin
            logic        r, s, f, rv;
            logic [31:0] rp;
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 5) == 0);
            rv = ($urandom_range(0, 7) == 0);
            rp = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rp = m_pc;
            if ($urandom_range(0, 24) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            step(r, s, f, rv, rp);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, meaning PC and instruction-address width.
REQ-002 Parameter INSTR_W, default 32, meaning instruction word width.
REQ-003 Parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 Parameter CNT_W, default 16, meaning fetch-counter width.
REQ-005 One clock and one reset. Reset is asynchronous and active-high. Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- stall_i  input  1  holds the PC and the IF/ID register.
- flush_i  input  1  turns the IF/ID contents into a bubble.
- redirect_valid_i  input  1  branch or jump taken by a later stage.
- redirect_pc_i  input  ADDR_W  target of the redirect.
- imem_addr_o  output  ADDR_W  instruction memory address; equals the current PC.
- imem_data_i  input  INSTR_W  instruction memory read data; combinational, same cycle.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- ifid_pc_o  output  ADDR_W  PC of the instruction in IF/ID.
- ifid_pc4_o  output  ADDR_W  that PC plus 4.
- ifid_instr_o  output  INSTR_W  the fetched instruction; NOP (all zero) when invalid.
- halted_o  output  1  fetch stopped because of a misaligned redirect.
- fetch_count_o  output  CNT_W  number of valid instructions loaded into IF/ID.

Function
REQ-006 FSM states are WAIT, RUN and HALT.
- WAIT lasts exactly one cycle after reset release, then moves to RUN.
- In WAIT, the PC holds RESET_PC and IF/ID stays invalid.
REQ-007 In RUN, each cycle's behaviour is chosen by priority, highest first:
- misaligned redirect
- aligned redirect
- stall
- normal fetch
REQ-008 Misaligned redirect is redirect_valid_i=1 with redirect_pc_i[1:0]≠0.
- Next state is HALT.
- The PC holds.
- IF/ID becomes invalid.
- halted_o=1 from the next cycle.
REQ-009 Aligned redirect:
- PC ← redirect_pc_i.
- IF/ID becomes invalid (implicit flush).
- stall_i is ignored in that cycle.
REQ-010 Stall (stall_i=1, no redirect):
- The PC holds.
- IF/ID holds, unless flush_i=1, in which case IF/ID becomes invalid. Flush beats stall for IF/ID.
REQ-011 Normal fetch:
- PC ← PC+4, wrapping modulo 2^ADDR_W.
- IF/ID ← {valid=1, PC, PC+4, imem_data_i}.
- If flush_i=1 in the same cycle, the PC still advances but IF/ID becomes invalid.
REQ-012 ifid_pc4_o also wraps modulo 2^ADDR_W; 32'hFFFF_FFFC yields 0.
REQ-013 Whenever IF/ID is made invalid, ifid_pc_o, ifid_pc4_o and ifid_instr_o are all loaded with 0.
REQ-014 HALT is terminal until reset.
- The PC holds.
- IF/ID stays invalid.
- stall, flush and redirect are ignored.
REQ-015 fetch_count_o increments by 1 on each cycle that loads valid=1 into IF/ID. It saturates at 2^CNT_W−1.
REQ-016 imem_addr_o is combinational from the PC register. Fetch latency is 1: the instruction at PC appears on ifid_* on the next cycle.
REQ-017 A redirect to the current PC value is legal and behaves as a flush plus a refetch.

Reset
REQ-018 rst_i=1 asynchronously forces the following, regardless of clock:
- PC=RESET_PC
- state=WAIT
- ifid_valid_o=0; ifid_pc_o, ifid_pc4_o and ifid_instr_o all 0
- halted_o=0
- fetch_count_o=0
REQ-019 Reset asserted mid-operation, including during stall or HALT, discards all state. The fetch then restarts through WAIT.
REQ-020 RESET_PC must be word-aligned; a misaligned value is a configuration error flagged at elaboration.

Structure
REQ-021 A shared package holds:
- the FSM state enumeration (WAIT, RUN, HALT)
- the NOP constant (0)
- the PC increment constant (4)
REQ-022 The PC register with its next-PC priority mux is one sub-module named fetch_pc_reg, parametrised by ADDR_W and RESET_PC. The IF/ID register, FSM and counter stay in the top.

Verification
REQ-023 Reset then 4 free-run cycles with imem returning 0x1111_0000+addr:
- imem_addr_o sequence is 0, 0, 4, 8 (0 twice: once in WAIT, once at the first RUN cycle).
- ifid_valid_o=0, 0, 1, 1.
- ifid_instr_o reaches 0x1111_0004 in the 4th cycle after reset release.
- fetch_count_o=2.
REQ-024 Aligned redirect at PC=0x10 with redirect_pc_i=0x40 and stall_i=1 in the same cycle:
- Next PC=0x40 and ifid_valid_o=0.
- One cycle later, ifid_pc_o=0x40.
REQ-025 stall_i=1 for 3 cycles at PC=0x8:
- PC stays 0x8; IF/ID is unchanged; fetch_count_o is unchanged.
- flush_i pulsed in the 2nd stall cycle gives ifid_valid_o=0 with ifid_instr_o=0.
REQ-026 redirect_pc_i=0x42:
- halted_o=1 next cycle; PC frozen.
- Later redirects and flushes have no effect.
- rst_i pulse clears halted_o and imem_addr_o becomes RESET_PC.
REQ-027 Wrap-around with ADDR_W=32: redirect to 0xFFFF_FFFC, one normal fetch → PC=0 and ifid_pc4_o=0.
REQ-028 Counter saturation with CNT_W=3: 10 valid fetches → fetch_count_o=7.
